// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs and pipeline-register controls of the sequencing controller
interface pipe_ctrl_if #(parameter int CNT_WIDTH = 32) ();
  logic load_use_hazard;
  logic branch_mispredict;
  logic imem_ready;
  logic dmem_ready;
  logic fence_i_req;
  logic pc_en;
  logic if_id_en;
  logic if_id_flush;
  logic id_ex_en;
  logic id_ex_flush;
  logic ex_mem_en;
  logic ex_mem_flush;
  logic mem_wb_en;
  logic mem_wb_flush;
  logic fence_i_done;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;
  modport master (
    input  load_use_hazard, branch_mispredict, imem_ready, dmem_ready, fence_i_req,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
           mem_wb_en, mem_wb_flush, fence_i_done, stall_cnt, flush_cnt
  );
  modport slave (
    output load_use_hazard, branch_mispredict, imem_ready, dmem_ready, fence_i_req,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
           mem_wb_en, mem_wb_flush, fence_i_done, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline enable/flush sequencing with fence.i drain FSM; PIPE_CTRL_PERF_EN builds stall/flush counters
module pipe_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_ctrl_if.master  bus
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  // {pc, if_id, id_ex, ex_mem, mem_wb} enables followed by {if_id, id_ex, ex_mem, mem_wb} flushes
  localparam logic [8:0] MEM_STALL = 9'b00001_0001;
  localparam logic [8:0] MISPRED   = 9'b11111_1100;
  localparam logic [8:0] LOAD_USE  = 9'b00111_0100;
  localparam logic [8:0] FETCH_GAP = 9'b01111_1000;
  localparam logic [8:0] FLOW      = 9'b11111_0000;
  localparam logic [8:0] FENCE_END = 9'b11111_1000;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] en;
  logic [3:0] fl;
  logic       done;
  // stage controls and next state; MEM stall dominates everything, an older mispredict kills any fence
  always_comb begin
    en = '0;
    fl = '0;
    done = 1'b0;
    state_d = state_q;
    cnt_d = cnt_q;
    if (!rst_n) state_d = RUN;
    else if (!bus.dmem_ready) {en, fl} = MEM_STALL;
    else if (bus.branch_mispredict) begin
      {en, fl} = MISPRED;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          {en, fl} = (bus.load_use_hazard || bus.fence_i_req) ? LOAD_USE : !bus.imem_ready ? FETCH_GAP : FLOW;
          if (!bus.load_use_hazard && bus.fence_i_req) begin
            state_d = DRAIN;
            cnt_d = 4'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          {en, fl} = LOAD_USE;
          cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
          state_d = (cnt_q == 4'd0) ? DONE : DRAIN;
        end
        DONE: begin
          {en, fl} = FENCE_END;
          done = 1'b1;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end
  // FSM state and drain counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en} = en;
  assign {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush} = fl;
  assign bus.fence_i_done = done;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_WIDTH-1:0] stall_q, stall_d, flush_q, flush_d;
  // saturating counters; a mispredict flush is applied exactly when MEM is not stalling
  always_comb begin
    stall_d = (!en[4] && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
    flush_d = (bus.dmem_ready && bus.branch_mispredict && !(&flush_q)) ? flush_q + 1'b1 : flush_q;
  end
  // perf counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencing controller for the 5-stage core. Every cycle it generates the enable and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. Its inputs are the hazard, memory-ready and branch-mispredict indications. It also runs the fence.i drain sequence as a small FSM, and optionally keeps stall and flush performance counters.

## Interface
- `DRAIN_CYCLES`, default 4: cycles spent in DRAIN before the fence completes; legal range 2..15.
- `CNT_WIDTH`, default 32: width of each performance counter.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `load_use_hazard`  in  1  instruction in ID consumes the result of a load in EX.
- `branch_mispredict`  in  1  EX resolved a branch/jump against its prediction.
- `imem_ready`  in  1  instruction memory returned a valid fetch this cycle.
- `dmem_ready`  in  1  data memory is not stalling the MEM stage.
- `fence_i_req`  in  1  fence.i in ID; level-held until `fence_i_done`.
- `pc_en`  out  1  PC register enable.
- `if_id_en`, `if_id_flush`  out  1 each  IF/ID register controls.
- `id_ex_en`, `id_ex_flush`  out  1 each  ID/EX register controls.
- `ex_mem_en`, `ex_mem_flush`  out  1 each  EX/MEM register controls.
- `mem_wb_en`, `mem_wb_flush`  out  1 each  MEM/WB register controls.
- `fence_i_done`  out  1  one-cycle pulse; fetch redirects to the fence's pc+4.
- `stall_cnt`  out  CNT_WIDTH  cycles in which `pc_en` was 0.
- `flush_cnt`  out  CNT_WIDTH  branch-mispredict flush events.

## Operation
- The FSM has three states:
  - RUN: normal operation.
  - DRAIN: older instructions retire while the fence holds.
  - DONE: one cycle that completes the fence.
- A flush is only ever asserted together with its enable. A register with enable 0 holds its value.
- RUN priority, highest first:
  1. `!dmem_ready`: `pc_en`, `if_id_en`, `id_ex_en` and `ex_mem_en` are 0. `mem_wb_en=1` and `mem_wb_flush=1`, so a bubble goes to WB.
  2. `branch_mispredict`: all enables 1; `if_id_flush=1` and `id_ex_flush=1`.
  3. `load_use_hazard`: `pc_en=0` and `if_id_en=0`; `id_ex_en=1` and `id_ex_flush=1`; all other enables 1.
  4. `fence_i_req`: same outputs as case 3, and next state is DRAIN with the counter loaded to `DRAIN_CYCLES-1`.
  5. `!imem_ready`: `pc_en=0`; `if_id_en=1` and `if_id_flush=1`; all other enables 1.
  6. Otherwise all enables are 1 and all flushes are 0.
- DRAIN:
  - Base outputs are the same as case 3.
  - If `!dmem_ready`, case 1 outputs apply and the counter holds.
  - Otherwise the counter decrements; when it reaches 0, next state is DONE.
- DONE (one cycle):
  - `fence_i_done=1`, `if_id_en=1`, `if_id_flush=1`, `pc_en=1`; next state is RUN.
  - If `!dmem_ready` in DONE, case 1 outputs apply, `fence_i_done=0`, and the FSM stays in DONE.
- A `branch_mispredict` while in DRAIN or DONE comes from an older instruction, so it kills the fence. The FSM applies case 2 outputs, returns to RUN, and `fence_i_done` stays 0.
- A `branch_mispredict` together with `!dmem_ready` is handled as case 1. The mispredict is acted on when EX is released, because EX holds its value.

## Timing
- All enable, flush and `fence_i_done` outputs are combinational from the current state and the inputs. They take effect at the next rising edge.
- State and counter are registered.
- While `rst_n=0`: all enables are 0, all flushes are 0, `fence_i_done=0`, state is RUN, the drain counter is 0 and both perf counters are 0.
- Reset mid-DRAIN aborts the fence with no `fence_i_done`.
- Fence latency, from the first cycle of `fence_i_req` in RUN to `fence_i_done`, is `DRAIN_CYCLES+1` cycles plus one cycle per cycle with `dmem_ready=0`.
- `stall_cnt` increments by 1 in every cycle with `pc_en=0` outside reset. `flush_cnt` increments on every cycle where case 2 outputs are applied.
- Both counters saturate at all-ones and do not wrap.

## Configuration
- Macro `PIPE_CTRL_PERF_EN`:
  - Defined: the `stall_cnt` and `flush_cnt` registers and their incrementers are built.
  - Undefined: no counter logic is built. The ports remain and are tied to 0, and all other behaviour is identical.

## Test plan
- Reset then idle with all readies 1 and no hazards: all enables 1 and all flushes 0 from the first cycle after `rst_n` rises. Counters stay 0.
- Pulse `load_use_hazard` for 1 cycle: that cycle `pc_en=0`, `if_id_en=0`, `id_ex_flush=1`. `stall_cnt` reads 1 afterwards.
- Assert `branch_mispredict` and `load_use_hazard` together: mispredict wins, giving `if_id_flush=1`, `id_ex_flush=1` and `pc_en=1`. `flush_cnt` reads 1.
- Hold `fence_i_req` with `DRAIN_CYCLES=4` and `dmem_ready` dropped for 2 cycles mid-drain: `fence_i_done` pulses exactly 7 cycles after the request, for 1 cycle. The FSM then returns to RUN.
- Assert `branch_mispredict` on the 2nd DRAIN cycle: state returns to RUN, `fence_i_done` never pulses, and case 2 outputs apply that cycle.
- Preload `flush_cnt` to all-ones with `CNT_WIDTH=4` by forcing 16 mispredicts, then one more mispredict: `flush_cnt` stays at 15. With `PIPE_CTRL_PERF_EN` undefined, both counters read 0 throughout.
